// File: rtl/i2c_slave_rx_pkg.sv
// Shared types and constants for the two-wire slave receiver: FSM state
// encodings, open-drain drive levels and the register-pointer wrap helper.
package i2c_slave_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_ADDR_ACK = 3'd2,
    ST_PTR      = 3'd3,
    ST_PTR_ACK  = 3'd4,
    ST_DATA     = 3'd5,
    ST_DATA_ACK = 3'd6,
    ST_IGNORE   = 3'd7
  } state_e;

  // SDA_oe levels: ACK pulls the line low, NACK/release leaves it to the pull-up
  localparam logic OE_ACK = 1'b1;
  localparam logic OE_REL = 1'b0;

  localparam logic [3:0] BYTE_BITS = 4'd8;

  function automatic logic [1:0] ptr_wrap_inc(input logic [1:0] ptr,
                                              input logic [1:0] last);
    return (ptr == last) ? 2'd0 : ptr + 2'd1;
  endfunction

endpackage

// File: rtl/i2c_slave_rx_sync_edge.sv
// Multi-flop synchronizer for one bus pin plus a history flop that yields
// single-cycle rise/fall pulses on the synchronized level.
module i2c_slave_rx_sync_edge #(
  parameter int SYNC_STG = 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic lvl_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STG-1:0] sync_q;
  logic                hist_q;

  // Reset to the idle-bus level so leaving reset never fakes an edge
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q <= '1;
      hist_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STG-2:0], d_i};
      hist_q <= sync_q[SYNC_STG-1];
    end
  end

  assign lvl_o  = sync_q[SYNC_STG-1];
  assign rise_o = sync_q[SYNC_STG-1] & ~hist_q;
  assign fall_o = ~sync_q[SYNC_STG-1] & hist_q;

endmodule

// File: rtl/i2c_slave_rx.sv
// Write-only two-wire slave: decodes START/STOP, matches DEV_ADDR, loads a
// register pointer and writes data bytes into a small auto-incrementing file.
module i2c_slave_rx
  import i2c_slave_rx_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h42,
  parameter int         NUM_REGS = 3,
  parameter int         SYNC_STG = 2
) (
  input  logic       CLOCK_50,
  input  logic       rst_n,
  input  logic       CL,
  input  logic       SDA_in,
  output logic       SDA_oe,
  output logic [7:0] REG1_OUT,
  output logic [7:0] REG2_OUT,
  output logic [7:0] REG3_OUT,
  output logic       wr_strobe,
  output logic [1:0] wr_index,
  output logic [7:0] wr_data,
  output logic       busy
);

  localparam logic [1:0] PTR_LAST = 2'(NUM_REGS - 1);
  localparam logic [7:0] PTR_LIM  = 8'(NUM_REGS);

  logic cl_lvl, cl_rise, cl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_slave_rx_sync_edge #(.SYNC_STG(SYNC_STG)) u_sync_cl (
    .clk_i  (CLOCK_50),
    .rst_n_i(rst_n),
    .d_i    (CL),
    .lvl_o  (cl_lvl),
    .rise_o (cl_rise),
    .fall_o (cl_fall)
  );

  i2c_slave_rx_sync_edge #(.SYNC_STG(SYNC_STG)) u_sync_sda (
    .clk_i  (CLOCK_50),
    .rst_n_i(rst_n),
    .d_i    (SDA_in),
    .lvl_o  (sda_lvl),
    .rise_o (sda_rise),
    .fall_o (sda_fall)
  );

  // An SDA edge coinciding with a CL edge is data, never a bus condition
  logic cl_edge, start_det, stop_det;
  assign cl_edge   = cl_rise | cl_fall;
  assign start_det = cl_lvl & ~cl_edge & sda_fall;
  assign stop_det  = cl_lvl & ~cl_edge & sda_rise;

  state_e     state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [1:0] ptr_q, ptr_d;
  logic       sda_oe_q, sda_oe_d;
  logic       busy_q, busy_d;
  logic       wr_stb_q, wr_stb_d;
  logic [1:0] wr_idx_q, wr_idx_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic [7:0] regs_q [NUM_REGS];
  logic [7:0] regs_d [NUM_REGS];
  logic [7:0] byte_in;

  assign byte_in = {shift_q[6:0], sda_lvl};

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    ptr_d     = ptr_q;
    sda_oe_d  = sda_oe_q;
    busy_d    = busy_q;
    wr_stb_d  = 1'b0;
    wr_idx_d  = wr_idx_q;
    wr_data_d = wr_data_q;
    regs_d    = regs_q;

    if (start_det) begin
      state_d   = ST_ADDR;
      bit_cnt_d = '0;
      sda_oe_d  = OE_REL;
    end else if (stop_det) begin
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
      sda_oe_d  = OE_REL;
      busy_d    = 1'b0;
    end else begin
      unique case (state_q)
        ST_ADDR, ST_PTR, ST_DATA: begin
          if (cl_rise && bit_cnt_q != BYTE_BITS) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 4'd1;
            // Data bytes commit on the rise of bit 8, ahead of the ACK slot
            if (state_q == ST_DATA && bit_cnt_q == BYTE_BITS - 4'd1) begin
              regs_d[ptr_q] = byte_in;
              wr_stb_d      = 1'b1;
              wr_idx_d      = ptr_q;
              wr_data_d     = byte_in;
              ptr_d         = ptr_wrap_inc(ptr_q, PTR_LAST);
            end
          end else if (cl_fall && bit_cnt_q == BYTE_BITS) begin
            bit_cnt_d = '0;
            if (state_q == ST_ADDR) begin
              if (shift_q[7:1] == DEV_ADDR && !shift_q[0]) begin
                sda_oe_d = OE_ACK;
                busy_d   = 1'b1;
                state_d  = ST_ADDR_ACK;
              end else begin
                state_d  = ST_IGNORE;
              end
            end else if (state_q == ST_PTR) begin
              if (shift_q < PTR_LIM) begin
                ptr_d    = shift_q[1:0];
                sda_oe_d = OE_ACK;
                state_d  = ST_PTR_ACK;
              end else begin
                state_d  = ST_IGNORE;
              end
            end else begin
              sda_oe_d = OE_ACK;
              state_d  = ST_DATA_ACK;
            end
          end
        end
        ST_ADDR_ACK: begin
          if (cl_fall) begin
            sda_oe_d = OE_REL;
            state_d  = ST_PTR;
          end
        end
        ST_PTR_ACK, ST_DATA_ACK: begin
          if (cl_fall) begin
            sda_oe_d = OE_REL;
            state_d  = ST_DATA;
          end
        end
        ST_IGNORE: sda_oe_d = OE_REL;
        default:   ;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      ptr_q     <= '0;
      sda_oe_q  <= OE_REL;
      busy_q    <= 1'b0;
      wr_stb_q  <= 1'b0;
      wr_idx_q  <= '0;
      wr_data_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      ptr_q     <= ptr_d;
      sda_oe_q  <= sda_oe_d;
      busy_q    <= busy_d;
      wr_stb_q  <= wr_stb_d;
      wr_idx_q  <= wr_idx_d;
      wr_data_q <= wr_data_d;
      regs_q    <= regs_d;
    end
  end

  assign REG1_OUT = regs_q[0];

  generate
    if (NUM_REGS >= 2) begin : g_reg2
      assign REG2_OUT = regs_q[1];
    end else begin : g_no_reg2
      assign REG2_OUT = 8'h00;
    end
    if (NUM_REGS >= 3) begin : g_reg3
      assign REG3_OUT = regs_q[2];
    end else begin : g_no_reg3
      assign REG3_OUT = 8'h00;
    end
  endgenerate

  assign SDA_oe    = sda_oe_q;
  assign busy      = busy_q;
  assign wr_strobe = wr_stb_q;
  assign wr_index  = wr_idx_q;
  assign wr_data   = wr_data_q;

endmodule
